fetch_unit: RTL and testbench

- Instruction-fetch front end. Generates the PC, issues in-order requests to instruction memory, and buffers returned words in a prefetch FIFO.
- Presents {inst, pc} to the IF/ID pipeline register over a valid/ready handshake.
- Consumes the EX-stage redirect (jump/branch target), flushes stale work, and restarts fetch at the target.
- Decouples decode stalls from memory latency.

---
 rtl/fetch_unit_pkg.sv | 29 ++
 rtl/fetch_unit_if.sv | 24 ++
 rtl/fetch_fifo.sv | 83 ++++++++
 rtl/fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_fetch_unit.sv | 395 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
        if (en && (value != 32'hFFFF_FFFF)) begin
            return value + 32'd1;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between the fetch unit (master) and memory (slave).
interface fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_resp_valid,
        input  imem_resp_data
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_resp_valid,
        output imem_resp_data
    );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {inst, pc} entries; power-of-two depth, synchronous flush and reset.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    output fetch_entry_t  head_o,
    output logic [CW-1:0] count_o,
    output logic          empty_o
);
    localparam logic [AW-1:0] PTR_MASK   = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok_s, pop_ok_s;

    assign empty_o   = (count_q == {CW{1'b0}});
    assign pop_ok_s  = pop_i & ~empty_o;
    // A push into a full FIFO is only accepted alongside a pop.
    assign push_ok_s = push_i & ((count_q != FULL_COUNT) | pop_ok_s);
    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = (wr_ptr_q + AW'(1)) & PTR_MASK;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = (rd_ptr_q + AW'(1)) & PTR_MASK;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are only observed through valid pointers.
    always_ff @(posedge clk) begin
        if (push_ok_s && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, credit-limited in-order fetch, prefetch FIFO.
// Optional performance counters are built when FETCH_PERF_EN is defined.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] NOP_INST   = fetch_unit_pkg::NOP_INST
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master imem,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         ifid_valid,
    input  logic         ifid_ready,
    output logic [31:0]  ifid_inst,
    output logic [31:0]  ifid_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  perf_redirects,
    output logic [31:0]  perf_discards,
    output logic [31:0]  perf_starve
`endif
);
    import fetch_unit_pkg::*;

    localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    fetch_state_t  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] live_q, live_d;
    logic [CW-1:0] stale_q, stale_d;
    logic [CW-1:0] fifo_count_s;
    logic          fifo_empty_s;
    logic          credit_ok_s, req_valid_s, accept_s;
    logic          resp_live_s, resp_drop_s, push_s, pop_s;
    fetch_entry_t  push_entry_s, head_s;

    // Issue needs room for the reply in the FIFO and a free tag among all outstanding requests.
    assign credit_ok_s = (({1'b0, fifo_count_s} + {1'b0, live_q}) < DEPTH_W) &&
                         (({1'b0, live_q} + {1'b0, stale_q}) < DEPTH_W);

    assign accept_s     = req_valid_s & imem.imem_req_ready;
    assign resp_drop_s  = imem.imem_resp_valid & (stale_q != {CW{1'b0}});
    assign resp_live_s  = imem.imem_resp_valid & (stale_q == {CW{1'b0}});
    assign push_s       = resp_live_s & ~redirect_valid;
    assign pop_s        = ifid_valid & ifid_ready & ~redirect_valid;
    assign push_entry_s = '{inst: imem.imem_resp_data, pc: resp_pc_q};

    // FSM next state and request strobe.
    always_comb begin
        state_d     = state_q;
        req_valid_s = 1'b0;
        case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                if (redirect_valid) begin
                    state_d = RUN;
                end else if (credit_ok_s) begin
                    req_valid_s = 1'b1;
                    state_d     = RUN;
                end else begin
                    state_d = STALL;
                end
            end
            STALL: begin
                if (redirect_valid || credit_ok_s) begin
                    state_d = RUN;
                end else begin
                    state_d = STALL;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // PC and outstanding-request bookkeeping; a redirect overrides everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        live_d     = live_q;
        stale_d    = stale_q;
        if (redirect_valid) begin
            fetch_pc_d = align_word(redirect_pc);
            resp_pc_d  = align_word(redirect_pc);
            live_d     = {CW{1'b0}};
            // A reply landing now belongs to the old stream and retires one old request.
            if (imem.imem_resp_valid) begin
                stale_d = stale_q + live_q - CW'(1);
            end else begin
                stale_d = stale_q + live_q;
            end
        end else begin
            if (accept_s) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (push_s) begin
                resp_pc_d = resp_pc_q + 32'd4;
            end else begin
                resp_pc_d = resp_pc_q;
            end
            case ({accept_s, resp_live_s})
                2'b10:   live_d = live_q + CW'(1);
                2'b01:   live_d = live_q - CW'(1);
                default: live_d = live_q;
            endcase
            if (resp_drop_s) begin
                stale_d = stale_q - CW'(1);
            end else begin
                stale_d = stale_q;
            end
        end
    end

    // State and bookkeeping registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= BOOT;
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            live_q     <= {CW{1'b0}};
            stale_q    <= {CW{1'b0}};
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            live_q     <= live_d;
            stale_q    <= stale_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (push_s),
        .push_data_i (push_entry_s),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .count_o     (fifo_count_s),
        .empty_o     (fifo_empty_s)
    );

    assign imem.imem_req_valid = req_valid_s;
    assign imem.imem_req_addr  = fetch_pc_q;
    assign ifid_valid          = ~fifo_empty_s;
    assign ifid_inst           = ifid_valid ? head_s.inst : NOP_INST;
    assign ifid_pc             = ifid_valid ? head_s.pc : 32'h0000_0000;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_redirects_q, perf_discards_q, perf_starve_q;

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_redirects_q <= 32'h0000_0000;
            perf_discards_q  <= 32'h0000_0000;
            perf_starve_q    <= 32'h0000_0000;
        end else begin
            perf_redirects_q <= sat_inc(perf_redirects_q, redirect_valid);
            perf_discards_q  <= sat_inc(perf_discards_q,
                                        imem.imem_resp_valid & (redirect_valid | resp_drop_s));
            perf_starve_q    <= sat_inc(perf_starve_q, ifid_ready & ~ifid_valid);
        end
    end

    assign perf_redirects = perf_redirects_q;
    assign perf_discards  = perf_discards_q;
    assign perf_starve    = perf_starve_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomised bench for fetch_unit with an in-order latency memory model.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic        ifid_ready;
    logic [31:0] ifid_inst;
    logic [31:0] ifid_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_redirects, perf_discards, perf_starve;
`endif

    fetch_unit_if bus ();

    fetch_unit #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (DEPTH),
        .NOP_INST   (32'h0000_0013)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_valid     (ifid_valid),
        .ifid_ready     (ifid_ready),
        .ifid_inst      (ifid_inst),
        .ifid_pc        (ifid_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_redirects (perf_redirects),
        .perf_discards  (perf_discards),
        .perf_starve    (perf_starve)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          lat_fixed = 1;
    int          occ = 0;
    int          stale_n = 0;
    int          pops = 0;
    int          accepts = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_req = 32'h0;
    logic        prev_pend = 1'b0;
    logic [31:0] q_addr[$];
    int          q_due[$];

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a >> 2) * 32'h0100_0003 + 32'h0000_0093;
    endfunction

    // Drive this cycle's memory response, then let combinational outputs settle.
    task automatic begin_cycle();
        if (rst && q_due.size() > 0 && q_due[0] <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = rom(q_addr[0]);
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
        end
        #1;
    endtask

    // Scoreboard the settled cycle, update the model, advance to the next negedge.
    task automatic end_cycle();
        logic pop_m;
        int   lat;
        if (!rst) begin
            q_addr.delete();
            q_due.delete();
            occ = 0; stale_n = 0; exp_pc = 32'h0; exp_req = 32'h0; prev_pend = 1'b0;
        end else begin
            total++;
            if (ifid_valid !== (occ > 0)) begin
                bad++; $display("FAIL ifid_valid: got %b want %b (cycle %0d)", ifid_valid, occ > 0, cyc);
            end
            total++;
            if (occ > 0) begin
                if (ifid_pc !== exp_pc || ifid_inst !== rom(exp_pc)) begin
                    bad++; $display("FAIL ifid_head: got pc=%h inst=%h want pc=%h inst=%h", ifid_pc, ifid_inst, exp_pc, rom(exp_pc));
                end
            end else begin
                if (ifid_pc !== 32'h0 || ifid_inst !== NOP) begin
                    bad++; $display("FAIL ifid_idle: got pc=%h inst=%h want pc=0 inst=%h", ifid_pc, ifid_inst, NOP);
                end
            end
            if (bus.imem_req_valid === 1'b1) begin
                total++;
                if (bus.imem_req_addr !== exp_req || redirect_valid) begin
                    bad++; $display("FAIL req_addr: got %h redirect=%b want %h redirect=0", bus.imem_req_addr, redirect_valid, exp_req);
                end
            end
            if (prev_pend && !redirect_valid) begin
                total++;
                if (bus.imem_req_valid !== 1'b1) begin
                    bad++; $display("FAIL req_hold: got valid=%b want 1", bus.imem_req_valid);
                end
            end
            total++;
            if (q_due.size() > DEPTH || occ > DEPTH) begin
                bad++; $display("FAIL credit: got inflight=%0d fifo=%0d want both <= %0d", q_due.size(), occ, DEPTH);
            end
            pop_m = (occ > 0) && ifid_ready && !redirect_valid;
            if (bus.imem_resp_valid) begin
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
                if (redirect_valid) begin
                    stale_n = stale_n;
                end else if (stale_n > 0) begin
                    stale_n--;
                end else begin
                    occ++;
                end
            end
            if (pop_m) begin
                occ--; exp_pc += 32'd4; pops++;
            end
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 4));
                q_addr.push_back(bus.imem_req_addr);
                q_due.push_back(cyc + lat);
                exp_req += 32'd4;
                accepts++;
            end
            if (redirect_valid) begin
                stale_n = q_due.size();
                occ     = 0;
                exp_pc  = {redirect_pc[31:2], 2'b00};
                exp_req = {redirect_pc[31:2], 2'b00};
            end
            prev_pend = bus.imem_req_valid && !bus.imem_req_ready && !redirect_valid;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic step();
        begin_cycle();
        end_cycle();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        redirect_valid = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_addr [4];
        exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC};
        ifid_ready = 1'b1; bus.imem_req_ready = 1'b1; lat_fixed = 1;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            begin_cycle();
            if (c == 0) begin
                total++;
                if (bus.imem_req_valid !== 1'b0 || ifid_valid !== 1'b0 || ifid_inst !== NOP || ifid_pc !== 32'h0) begin
                    bad++; $display("FAIL reset_outputs: got req=%b v=%b inst=%h pc=%h want 0 0 %h 0", bus.imem_req_valid, ifid_valid, ifid_inst, ifid_pc, NOP);
                end
`ifdef FETCH_PERF_EN
                total++;
                if (perf_redirects !== 32'h0 || perf_discards !== 32'h0 || perf_starve !== 32'h0) begin
                    bad++; $display("FAIL reset_perf: got %h %h %h want 0", perf_redirects, perf_discards, perf_starve);
                end
`endif
            end
            if (c >= 1 && c <= 4) begin
                total++;
                if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== exp_addr[c-1]) begin
                    bad++; $display("FAIL boot_req: got v=%b addr=%h want v=1 addr=%h", bus.imem_req_valid, bus.imem_req_addr, exp_addr[c-1]);
                end
            end
            if (c == 3) begin
                total++;
                if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0 || ifid_inst !== 32'h0000_0093) begin
                    bad++; $display("FAIL first_inst: got v=%b pc=%h inst=%h want 1 0 00000093", ifid_valid, ifid_pc, ifid_inst);
                end
            end
            end_cycle();
        end
    endtask

    task automatic test_stall();
        int  a0;
        bit  found;
        ifid_ready = 1'b0; bus.imem_req_ready = 1'b1; lat_fixed = 1;
        do_reset();
        a0 = accepts;
        for (int c = 0; c < 10; c++) step();
        begin_cycle();
        total++;
        if (accepts - a0 !== 4) begin
            bad++; $display("FAIL stall_accepts: got %0d want 4", accepts - a0);
        end
        total++;
        if (bus.imem_req_valid !== 1'b0 || dut.state_q !== STALL) begin
            bad++; $display("FAIL stall_state: got req=%b state=%0d want 0 %0d", bus.imem_req_valid, dut.state_q, STALL);
        end
        total++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h0) begin
            bad++; $display("FAIL stall_head: got v=%b pc=%h want 1 0", ifid_valid, ifid_pc);
        end
        end_cycle();
        ifid_ready = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            begin_cycle();
            if (bus.imem_req_valid === 1'b1) begin
                found = 1'b1;
                total++;
                if (bus.imem_req_addr !== 32'h10) begin
                    bad++; $display("FAIL stall_resume: got %h want 00000010", bus.imem_req_addr);
                end
            end
            end_cycle();
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL stall_resume_timeout: got no request want addr 00000010");
        end
    endtask

    task automatic test_redirect();
        bit found;
        ifid_ready = 1'b1; bus.imem_req_ready = 1'b1; lat_fixed = 3;
        do_reset();
        step();
        step();
        step();
        bus.imem_req_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        begin_cycle();
        total++;
        if (bus.imem_req_valid !== 1'b0) begin
            bad++; $display("FAIL redir_withdraw: got req=%b want 0", bus.imem_req_valid);
        end
        end_cycle();
        redirect_valid = 1'b0; bus.imem_req_ready = 1'b1;
        begin_cycle();
        total++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h100) begin
            bad++; $display("FAIL redir_req: got v=%b addr=%h want 1 00000100", bus.imem_req_valid, bus.imem_req_addr);
        end
        end_cycle();
        found = 1'b0;
        for (int c = 0; c < 15 && !found; c++) begin
            begin_cycle();
            if (ifid_valid === 1'b1) begin
                found = 1'b1;
                total++;
                if (ifid_pc !== 32'h100 || ifid_inst !== 32'h4000_0153) begin
                    bad++; $display("FAIL redir_first: got pc=%h inst=%h want 00000100 40000153", ifid_pc, ifid_inst);
                end
            end
            end_cycle();
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL redir_timeout: got no ifid_valid want pc 00000100");
        end
    endtask

    task automatic test_redirect_coincident();
        bit found;
        ifid_ready = 1'b1; bus.imem_req_ready = 1'b1; lat_fixed = 1;
        do_reset();
        for (int c = 0; c < 4; c++) step();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0040;
        begin_cycle();
        total++;
        if (ifid_valid !== 1'b1 || ifid_pc !== 32'h4) begin
            bad++; $display("FAIL coinc_pre: got v=%b pc=%h want 1 00000004", ifid_valid, ifid_pc);
        end
        end_cycle();
        redirect_valid = 1'b0;
        begin_cycle();
        total++;
        if (ifid_valid !== 1'b0 || ifid_inst !== NOP || ifid_pc !== 32'h0) begin
            bad++; $display("FAIL coinc_flush: got v=%b inst=%h pc=%h want 0 %h 0", ifid_valid, ifid_inst, ifid_pc, NOP);
        end
        total++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h40) begin
            bad++; $display("FAIL coinc_req: got v=%b addr=%h want 1 00000040", bus.imem_req_valid, bus.imem_req_addr);
        end
        end_cycle();
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            begin_cycle();
            if (ifid_valid === 1'b1) begin
                found = 1'b1;
                total++;
                if (ifid_pc !== 32'h40) begin
                    bad++; $display("FAIL coinc_first: got pc=%h want 00000040", ifid_pc);
                end
            end
            end_cycle();
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL coinc_timeout: got no ifid_valid want pc 00000040");
        end
    endtask

    task automatic test_random();
        int p0;
        lat_fixed = 0; bus.imem_req_ready = 1'b1; ifid_ready = 1'b1;
        do_reset();
        p0 = pops;
        for (int c = 0; c < 10000; c++) begin
            bus.imem_req_ready = ($urandom_range(0, 3) != 0);
            ifid_ready         = ($urandom_range(0, 2) != 0);
            redirect_valid     = ($urandom_range(0, 49) == 0);
            redirect_pc        = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'($urandom);
            step();
        end
        redirect_valid = 1'b0;
        total++;
        if (pops - p0 < 1000) begin
            bad++; $display("FAIL random_progress: got %0d pops want >= 1000", pops - p0);
        end
    endtask

    task automatic test_reset_mid();
        ifid_ready = 1'b0; bus.imem_req_ready = 1'b1; lat_fixed = 1;
        do_reset();
        for (int c = 0; c < 10; c++) step();
        begin_cycle();
        total++;
        if (ifid_valid !== 1'b1) begin
            bad++; $display("FAIL mid_full: got v=%b want 1", ifid_valid);
        end
        end_cycle();
        rst = 1'b0;
        step();
        rst = 1'b1;
        begin_cycle();
        total++;
        if (bus.imem_req_valid !== 1'b0 || ifid_valid !== 1'b0 || ifid_inst !== NOP || ifid_pc !== 32'h0) begin
            bad++; $display("FAIL mid_reset: got req=%b v=%b inst=%h pc=%h want 0 0 %h 0", bus.imem_req_valid, ifid_valid, ifid_inst, ifid_pc, NOP);
        end
`ifdef FETCH_PERF_EN
        total++;
        if (perf_redirects !== 32'h0 || perf_discards !== 32'h0 || perf_starve !== 32'h0) begin
            bad++; $display("FAIL mid_perf: got %h %h %h want 0", perf_redirects, perf_discards, perf_starve);
        end
`endif
        end_cycle();
        ifid_ready = 1'b1;
        begin_cycle();
        total++;
        if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h0) begin
            bad++; $display("FAIL mid_restart: got v=%b addr=%h want 1 00000000", bus.imem_req_valid, bus.imem_req_addr);
        end
        end_cycle();
        for (int c = 0; c < 6; c++) step();
    endtask

    initial begin
        rst = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        ifid_ready = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data = 32'h0;
        @(negedge clk);
        test_reset();
        test_stall();
        test_redirect();
        test_redirect_coincident();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
